// File: rtl/regfile_scoreboard.sv
// Register file with byte-enable writes, same-cycle write bypass to registered
// read ports, and a per-register pending (busy) scoreboard.
module regfile_scoreboard #(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    parameter  int NRPORTS = 2,
    localparam int AW      = $clog2(NREGS),
    localparam int NB      = XLEN / 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    rd_en,
    input  logic [NRPORTS*AW-1:0]   rd_addr,
    output logic [NRPORTS*XLEN-1:0] rd_data,
    output logic [NRPORTS-1:0]      rd_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic [NB-1:0]           wr_be,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_addr,
    output logic                    all_clear
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]         regs_q [NREGS];
    logic [XLEN-1:0]         regs_d [NREGS];
    logic [NREGS-1:0]        busy_q, busy_d;
    logic [NRPORTS*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRPORTS-1:0]      rd_busy_q, rd_busy_d;
    logic                    all_clear_q, all_clear_d;

    logic                    wr_hit;
    logic                    sb_hit;
    logic [XLEN-1:0]         wr_old;
    logic [XLEN-1:0]         wr_merged;
    logic [AW-1:0]           ra;

    // Register 0 and addresses beyond NREGS are never stored or marked busy.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        rd_data_d   = rd_data_q;
        rd_busy_d   = rd_busy_q;
        wr_hit      = wr_en && addr_ok(wr_addr);
        sb_hit      = sb_set && addr_ok(sb_addr);
        wr_old      = '0;
        wr_merged   = '0;
        ra          = '0;

        if (wr_hit) begin
            wr_old = regs_q[wr_addr];
            for (int b = 0; b < NB; b++) begin
                wr_merged[b*8 +: 8] = wr_be[b] ? wr_data[b*8 +: 8] : wr_old[b*8 +: 8];
            end
            regs_d[wr_addr] = wr_merged;
            busy_d[wr_addr] = 1'b0;
        end

        // Set is applied after clear so a same-cycle issue keeps the register pending.
        if (sb_hit) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // Reads sample the next-state arrays, which gives write bypass for free.
        if (rd_en) begin
            for (int p = 0; p < NRPORTS; p++) begin
                ra = rd_addr[p*AW +: AW];
                if (addr_ok(ra)) begin
                    rd_data_d[p*XLEN +: XLEN] = regs_d[ra];
                    rd_busy_d[p]              = busy_d[ra];
                end else begin
                    rd_data_d[p*XLEN +: XLEN] = '0;
                    rd_busy_d[p]              = 1'b0;
                end
            end
        end

        all_clear_d = ~|busy_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            rd_data_q   <= '0;
            rd_busy_q   <= '0;
            all_clear_q <= 1'b1;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_busy_q   <= rd_busy_d;
            all_clear_q <= all_clear_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_busy   = rd_busy_q;
    assign all_clear = all_clear_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRPORTS = 2;
    localparam int AW = 5;
    localparam int NB = 4;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic                    rd_en;
    logic [NRPORTS*AW-1:0]   rd_addr;
    logic [NRPORTS*XLEN-1:0] rd_data;
    logic [NRPORTS-1:0]      rd_busy;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [XLEN-1:0]         wr_data;
    logic [NB-1:0]           wr_be;
    logic                    sb_set;
    logic [AW-1:0]           sb_addr;
    logic                    all_clear;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [XLEN-1:0] m_reg [NREGS];
    logic            m_busy [NREGS];
    logic [XLEN-1:0] m_rd_data [NRPORTS];
    logic            m_rd_busy [NRPORTS];
    logic            m_all_clear;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRPORTS)) dut (
        .CLK(CLK), .RESET(RESET), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .sb_set(sb_set), .sb_addr(sb_addr),
        .all_clear(all_clear)
    );

    always #5 CLK = ~CLK;

    task automatic model_update();
        int a;
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < NRPORTS; p++) begin
                m_rd_data[p] = '0;
                m_rd_busy[p] = 1'b0;
            end
            m_all_clear = 1'b1;
            return;
        end
        if (wr_en && wr_addr != 0) begin
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) m_reg[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            m_busy[wr_addr] = 1'b0;
        end
        if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
        if (rd_en) begin
            for (int p = 0; p < NRPORTS; p++) begin
                a = int'(rd_addr[p*AW +: AW]);
                m_rd_data[p] = (a == 0) ? '0 : m_reg[a];
                m_rd_busy[p] = (a == 0) ? 1'b0 : m_busy[a];
            end
        end
        m_all_clear = 1'b1;
        for (int i = 0; i < NREGS; i++)
            if (m_busy[i]) m_all_clear = 1'b0;
    endtask

    task automatic tick();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET = 1'b0; rd_en = 1'b0; wr_en = 1'b0; sb_set = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0; sb_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_busy !== '0) begin errors++; $display("FAIL reset_rd_busy got=%b exp=0", rd_busy); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL reset_all_clear got=%b exp=1", all_clear); end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = {5'd0, 5'd5};
        tick();
        checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_x5 got=%h exp=deadbeef", rd_data[31:0]); end
    endtask

    task automatic test_x0();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = {5'd0, 5'd0};
        tick();
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL x0_read got=%h exp=0", rd_data); end
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL x0_busy got=%b exp=00", rd_busy); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL x0_all_clear got=%b exp=1", all_clear); end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11223344; wr_be = 4'b1111;
        tick();
        wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
        rd_en = 1'b1; rd_addr = {5'd7, 5'd7};
        tick();
        checks++; if (rd_data[31:0] !== 32'h11BB33DD) begin errors++; $display("FAIL bypass_p0 got=%h exp=11bb33dd", rd_data[31:0]); end
        checks++; if (rd_data[63:32] !== 32'h11BB33DD) begin errors++; $display("FAIL bypass_p1 got=%h exp=11bb33dd", rd_data[63:32]); end
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd7};
        tick();
        checks++; if (rd_data[31:0] !== 32'h11BB33DD) begin errors++; $display("FAIL bypass_reread got=%h exp=11bb33dd", rd_data[31:0]); end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_en = 1'b1; rd_addr = {5'd9, 5'd9};
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_set_busy got=%b exp=11", rd_busy); end
        checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL sb_set_all_clear got=%b exp=0", all_clear); end
        sb_set = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099; wr_be = 4'b0000;
        tick();
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL wr_clear_busy got=%b exp=00", rd_busy); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL wr_clear_all_clear got=%b exp=1", all_clear); end
        sb_set = 1'b1; sb_addr = 5'd9;
        wr_data = 32'hCAFEF00D; wr_be = 4'b1111;
        tick();
        checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL set_wins_busy got=%b exp=11", rd_busy); end
        checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL set_wins_all_clear got=%b exp=0", all_clear); end
        checks++; if (rd_data[31:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL set_wins_data got=%h exp=cafef00d", rd_data[31:0]); end
        sb_set = 1'b0;
        tick();
        idle();
        tick();
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL sb_final_clear got=%b exp=1", all_clear); end
    endtask

    task automatic test_hold();
        idle();
        rd_en = 1'b1; rd_addr = {5'd7, 5'd5};
        tick();
        rd_en = 1'b0; rd_addr = {5'd5, 5'd7};
        sb_set = 1'b1; sb_addr = 5'd5;
        tick();
        checks++; if (rd_data !== {32'h11BB33DD, 32'hDEADBEEF}) begin errors++; $display("FAIL hold_data got=%h exp=11bb33dddeadbeef", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL hold_busy got=%b exp=00", rd_busy); end
        sb_set = 1'b0; rd_en = 1'b1;
        tick();
        checks++; if (rd_data !== {32'hDEADBEEF, 32'h11BB33DD}) begin errors++; $display("FAIL update_data got=%h exp=deadbeef11bb33dd", rd_data); end
        checks++; if (rd_busy !== 2'b10) begin errors++; $display("FAIL update_busy got=%b exp=10", rd_busy); end
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'b0000;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000055; wr_be = 4'b1111;
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        wr_en = 1'b0; sb_addr = 5'd3;
        rd_en = 1'b1; rd_addr = {5'd4, 5'd3};
        tick();
        checks++; if (rd_data[31:0] !== 32'h55 || rd_busy !== 2'b11) begin errors++; $display("FAIL pre_reset got=%h/%b exp=55/11", rd_data[31:0], rd_busy); end
        checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL pre_reset_all_clear got=%b exp=0", all_clear); end
        RESET = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h12345678; wr_be = 4'b1111;
        sb_set = 1'b1; sb_addr = 5'd8;
        tick();
        idle();
        checks++; if (rd_data !== '0 || rd_busy !== '0) begin errors++; $display("FAIL mid_reset_out got=%h/%b exp=0/00", rd_data, rd_busy); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL mid_reset_all_clear got=%b exp=1", all_clear); end
        rd_en = 1'b1; rd_addr = {5'd4, 5'd3};
        tick();
        checks++; if (rd_data !== '0 || rd_busy !== '0) begin errors++; $display("FAIL post_reset_x3x4 got=%h/%b exp=0/00", rd_data, rd_busy); end
        rd_addr = {5'd8, 5'd6};
        tick();
        checks++; if (rd_data !== '0 || rd_busy !== '0) begin errors++; $display("FAIL post_reset_x6x8 got=%h/%b exp=0/00", rd_data, rd_busy); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL post_reset_all_clear got=%b exp=1", all_clear); end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        // Favour a small set of registers so reads, writes and sets collide often.
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RESET   = ($urandom_range(0, 99) == 0);
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = {rnd_addr(), rnd_addr()};
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = rnd_addr();
            wr_data = $urandom;
            wr_be   = NB'($urandom_range(0, 15));
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_addr = rnd_addr();
            tick();
            for (int p = 0; p < NRPORTS; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== m_rd_data[p]) begin
                    errors++; $display("FAIL rand_rd_data cyc=%0d port=%0d got=%h exp=%h", n, p, rd_data[p*XLEN +: XLEN], m_rd_data[p]);
                end
                checks++;
                if (rd_busy[p] !== m_rd_busy[p]) begin
                    errors++; $display("FAIL rand_rd_busy cyc=%0d port=%0d got=%b exp=%b", n, p, rd_busy[p], m_rd_busy[p]);
                end
            end
            checks++;
            if (all_clear !== m_all_clear) begin
                errors++; $display("FAIL rand_all_clear cyc=%0d got=%b exp=%b", n, all_clear, m_all_clear);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rd_addr = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits (multiple of 8).
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of 2, >=2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRPORTS, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rd_en  input  1  read-output update enable for all ports.
REQ-007 SHALL have port rd_addr  input  NRPORTS*AW  read addresses; port p at [p*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRPORTS*XLEN  registered read data; port p at [p*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRPORTS  registered busy flag of each read address.
REQ-010 SHALL have port wr_en  input  1  write strobe.
REQ-011 SHALL have port wr_addr  input  AW  write address.
REQ-012 SHALL have port wr_data  input  XLEN  write data.
REQ-013 SHALL have port wr_be  input  XLEN/8  byte enables; bit i covers byte [8i+7:8i].
REQ-014 SHALL have port sb_set  input  1  mark register as pending (long-latency op issued).
REQ-015 SHALL have port sb_addr  input  AW  register to mark pending.
REQ-016 SHALL have port all_clear  output  1  registered, high when no register is pending.

Function
REQ-017 SHALL hold register 0 at constant zero: writes to address 0 ignored, reads of 0 return 0.
REQ-018 SHALL, on wr_en with wr_addr!=0, update only the bytes of that register whose wr_be bit is 1.
REQ-019 SHALL, on rd_en high, load each rd_data port on the clock edge, giving 1-cycle read latency.
REQ-020 SHALL hold rd_data and rd_busy unchanged when rd_en is low.
REQ-021 SHALL bypass same-cycle writes: when wr_en, wr_addr!=0 and rd_addr[p]==wr_addr, rd_data[p] is the byte-merge of wr_data (enabled bytes) and the stored value (other bytes).
REQ-022 SHALL keep one busy bit per register, with bit 0 always 0.
REQ-023 SHALL set busy[sb_addr] on sb_set when sb_addr!=0.
REQ-024 SHALL clear busy[wr_addr] on wr_en when wr_addr!=0, regardless of wr_be.
REQ-025 SHALL, when sb_set and wr_en target the same nonzero register in one cycle, leave busy at 1 (set wins) while the data write still occurs.
REQ-026 SHALL set rd_busy[p] to the next-state busy bit of rd_addr[p], including same-cycle set/clear, so that rd_busy stays aligned with rd_data.
REQ-027 SHALL set all_clear to 1 on the edge after the next-state busy vector is all zero, and to 0 otherwise.
REQ-028 SHALL give the same result when several read ports share one address.
REQ-029 SHALL produce no X on any output for in-range inputs; for NREGS not a power of 2, out-of-range addresses read 0 and writes to them are ignored.

Reset
REQ-030 SHALL, when RESET is high at a clock edge, clear all registers, clear all busy bits, set rd_data to 0, set rd_busy to 0 and set all_clear to 1.
REQ-031 SHALL give RESET priority over wr_en, sb_set and rd_en in the same cycle.
REQ-032 SHALL, when RESET is asserted mid-operation, discard all pending busy state, with no later write needed to clear it.

Verification
REQ-033 SHALL cover: after reset, write x5=0xDEADBEEF (wr_be=1111); next cycle read x5 on port 0 -> rd_data[0]=0xDEADBEEF one edge later.
REQ-034 SHALL cover: write x0=0xFFFFFFFF, then read x0 on all ports -> all read 0x00000000; sb_set x0 -> rd_busy=0, all_clear=1.
REQ-035 SHALL cover: x7=0x11223344, then write 0xAABBCCDD with wr_be=0101 while reading x7 in the same cycle -> rd_data=0x11BB33DD (bypass); same value on the next read.
REQ-036 SHALL cover: sb_set x9 -> rd_busy(x9)=1, all_clear=0; later write x9 -> busy cleared, all_clear=1 on the following edge; sb_set and write x9 in one cycle -> busy remains 1.
REQ-037 SHALL cover: with rd_en=0 and read addresses changed -> rd_data and rd_busy held; rd_en=1 -> they update.
REQ-038 SHALL cover: busy x3 and x4 with x3=0x55, then RESET for one cycle -> all registers 0, all_clear=1, rd_data=0.
